// File: rtl/rv32m_dispatch.sv
// RV32M dispatcher: accepts one request, drives an external multiplier (and divider
// when RV32M_DIV_EN is defined), guards the wait with a watchdog and returns the result.
module rv32m_dispatch (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o,
  output logic        mul_start_o,
  output logic [31:0] mul_op_A_o,
  output logic [31:0] mul_op_B_o,
  output logic        mul_ext_A_o,
  output logic        mul_ext_B_o,
  output logic        mul_upper_o,
  input  logic [31:0] mul_result_i,
  input  logic        mul_done_i
`ifdef RV32M_DIV_EN
  ,
  output logic        div_start_o,
  output logic [31:0] div_op_A_o,
  output logic [31:0] div_op_B_o,
  output logic        div_signed_o,
  output logic        div_rem_o,
  input  logic [31:0] div_result_i,
  input  logic        div_done_i
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [5:0] WDOG_LAST = 6'd62;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        illegal_q, illegal_d;
  logic [5:0]  wdog_q, wdog_d;

  logic        sel_div;
  logic        busy;
  logic        unit_done;
  logic [31:0] unit_result;
  logic [2:0]  mul_ctl;

  // {ext_A, ext_B, upper} for the four multiply flavours
  function automatic logic [2:0] mul_decode(input logic [1:0] f);
    case (f)
      2'b00:   return 3'b110;
      2'b01:   return 3'b111;
      2'b10:   return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

`ifdef RV32M_DIV_EN
  function automatic logic div_bypass(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Architectural results for divide-by-zero and signed overflow
  function automatic logic [31:0] div_bypass_result(input logic [2:0] f, input logic [31:0] a,
                                                    input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    return f[1] ? 32'd0 : 32'h8000_0000;
  endfunction
`endif

  assign sel_div = f3_q[2];
  assign busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign mul_ctl = mul_decode(f3_q[1:0]);

`ifdef RV32M_DIV_EN
  assign unit_done   = sel_div ? div_done_i   : mul_done_i;
  assign unit_result = sel_div ? div_result_i : mul_result_i;
`else
  assign unit_done   = mul_done_i;
  assign unit_result = mul_result_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f3_q      <= 3'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      rd_q      <= 5'd0;
      result_q  <= 32'd0;
      illegal_q <= 1'b0;
      wdog_q    <= 6'd0;
    end else begin
      f3_q      <= f3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    wdog_d    = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          f3_d      = funct3_i;
          rs1_d     = rs1_i;
          rs2_d     = rs2_i;
          rd_d      = rd_i;
          result_d  = 32'd0;
          illegal_d = 1'b0;
          if (!funct3_i[2]) begin
            state_d = S_ISSUE;
          end else begin
`ifdef RV32M_DIV_EN
            if (div_bypass(funct3_i, rs1_i, rs2_i)) begin
              result_d = div_bypass_result(funct3_i, rs1_i, rs2_i);
              state_d  = S_RESP;
            end else begin
              state_d = S_ISSUE;
            end
`else
            illegal_d = 1'b1;
            state_d   = S_RESP;
`endif
          end
        end
      end
      S_ISSUE: begin
        wdog_d  = 6'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 6'd1;
        if (unit_done) begin
          result_d = unit_result;
          state_d  = S_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          // 63rd wait cycle without completion: give up and flag it
          result_d  = 32'd0;
          illegal_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (result_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o        = (state_q == S_IDLE);
    result_valid_o = (state_q == S_RESP);
    mul_start_o    = 1'b0;
    mul_op_A_o     = 32'd0;
    mul_op_B_o     = 32'd0;
    mul_ext_A_o    = 1'b0;
    mul_ext_B_o    = 1'b0;
    mul_upper_o    = 1'b0;
    if (busy && !sel_div) begin
      mul_start_o = (state_q == S_ISSUE);
      mul_op_A_o  = rs1_q;
      mul_op_B_o  = rs2_q;
      mul_ext_A_o = mul_ctl[2];
      mul_ext_B_o = mul_ctl[1];
      mul_upper_o = mul_ctl[0];
    end
`ifdef RV32M_DIV_EN
    div_start_o  = 1'b0;
    div_op_A_o   = 32'd0;
    div_op_B_o   = 32'd0;
    div_signed_o = 1'b0;
    div_rem_o    = 1'b0;
    if (busy && sel_div) begin
      div_start_o  = (state_q == S_ISSUE);
      div_op_A_o   = rs1_q;
      div_op_B_o   = rs2_q;
      div_signed_o = !f3_q[0];
      div_rem_o    = f3_q[1];
    end
`endif
  end

  assign result_o  = result_q;
  assign rd_o      = rd_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_rv32m_dispatch.sv
// Self-checking bench for rv32m_dispatch with behavioural multiply/divide units.
module tb_rv32m_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] rs1_i = 32'd0;
  logic [31:0] rs2_i = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        illegal_o;
  logic        mul_start_o;
  logic [31:0] mul_op_A_o, mul_op_B_o;
  logic        mul_ext_A_o, mul_ext_B_o, mul_upper_o;
  logic [31:0] mul_result_i = 32'd0;
  logic        mul_done_i = 1'b0;
`ifdef RV32M_DIV_EN
  logic        div_start_o;
  logic [31:0] div_op_A_o, div_op_B_o;
  logic        div_signed_o, div_rem_o;
  logic [31:0] div_result_i = 32'd0;
  logic        div_done_i = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int unit_lat = 3;
  bit unit_hang = 1'b0;
  int mul_starts = 0;
  int div_starts = 0;
  int op_unstable = 0;
  int mul_cnt = 0;
  bit mul_chk = 1'b0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic m_ea = 1'b0, m_eb = 1'b0, m_up = 1'b0;

  rv32m_dispatch dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .rd_o(rd_o), .illegal_o(illegal_o),
    .mul_start_o(mul_start_o), .mul_op_A_o(mul_op_A_o), .mul_op_B_o(mul_op_B_o),
    .mul_ext_A_o(mul_ext_A_o), .mul_ext_B_o(mul_ext_B_o), .mul_upper_o(mul_upper_o),
    .mul_result_i(mul_result_i), .mul_done_i(mul_done_i)
`ifdef RV32M_DIV_EN
    ,
    .div_start_o(div_start_o), .div_op_A_o(div_op_A_o), .div_op_B_o(div_op_B_o),
    .div_signed_o(div_signed_o), .div_rem_o(div_rem_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Multiplier unit: 64-bit product of the operands extended as the dispatcher asks
  function automatic logic [31:0] mul_unit(input logic [31:0] a, input logic [31:0] b,
                                           input logic ea, input logic eb, input logic up);
    logic [63:0] xa, xb, p;
    xa = {{32{ea & a[31]}}, a};
    xb = {{32{eb & b[31]}}, b};
    p  = xa * xb;
    return up ? p[63:32] : p[31:0];
  endfunction

  always @(negedge clk_i) begin
    mul_done_i = 1'b0;
    if (rst_i) mul_chk = 1'b0;
    if (mul_start_o) begin
      mul_starts++;
      m_a = mul_op_A_o; m_b = mul_op_B_o;
      m_ea = mul_ext_A_o; m_eb = mul_ext_B_o; m_up = mul_upper_o;
      mul_cnt = unit_lat;
      mul_chk = 1'b1;
    end else if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_chk && (mul_op_A_o !== m_a || mul_op_B_o !== m_b || mul_ext_A_o !== m_ea ||
                      mul_ext_B_o !== m_eb || mul_upper_o !== m_up))
        op_unstable++;
      if (mul_cnt == 0 && !unit_hang) begin
        mul_result_i = mul_unit(m_a, m_b, m_ea, m_eb, m_up);
        mul_done_i = 1'b1;
      end
    end
  end

`ifdef RV32M_DIV_EN
  int div_cnt = 0;
  logic [31:0] d_a = 32'd0, d_b = 32'd0;
  logic d_s = 1'b0, d_r = 1'b0;

  function automatic logic [31:0] div_unit(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input logic r);
    longint x, y, q;
    if (b == 32'd0) return 32'd0;
    if (s) begin x = $signed(a); y = $signed(b); end
    else begin x = a; y = b; end
    q = r ? (x % y) : (x / y);
    return q[31:0];
  endfunction

  always @(negedge clk_i) begin
    div_done_i = 1'b0;
    if (div_start_o) begin
      div_starts++;
      d_a = div_op_A_o; d_b = div_op_B_o; d_s = div_signed_o; d_r = div_rem_o;
      div_cnt = unit_lat;
    end else if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0 && !unit_hang) begin
        div_result_i = div_unit(d_a, d_b, d_s, d_r);
        div_done_i = 1'b1;
      end
    end
  end
`endif

  // Reference: {bypass, illegal, result} straight from the RV32M definitions
  function automatic logic [33:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (f)
      3'd0: begin p = sa * sb; return {2'b00, p[31:0]}; end
      3'd1: begin p = sa * sb; return {2'b00, p[63:32]}; end
      3'd2: begin p = sa * ub; return {2'b00, p[63:32]}; end
      3'd3: begin p = ua * ub; return {2'b00, p[63:32]}; end
`ifdef RV32M_DIV_EN
      3'd4: begin
        if (b == 0) return {2'b10, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {2'b10, 32'h8000_0000};
        p = sa / sb; return {2'b00, p[31:0]};
      end
      3'd5: begin
        if (b == 0) return {2'b10, 32'hFFFF_FFFF};
        p = ua / ub; return {2'b00, p[31:0]};
      end
      3'd6: begin
        if (b == 0) return {2'b10, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {2'b10, 32'd0};
        p = sa % sb; return {2'b00, p[31:0]};
      end
      default: begin
        if (b == 0) return {2'b10, a};
        p = ua % ub; return {2'b00, p[31:0]};
      end
`else
      default: return {2'b11, 32'd0};
`endif
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // One request/response; assumes entry at a falling edge, returns at one.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold,
                       output logic [31:0] o_res, output logic [4:0] o_rd, output logic o_ill,
                       output int o_lat, output int o_starts, output int o_hold_bad);
    int n;
    mul_starts = 0;
    div_starts = 0;
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin @(negedge clk_i); n++; end
    valid_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b; rd_i = rd;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    o_lat = 1;
    while (result_valid_o !== 1'b1 && o_lat < 200) begin @(negedge clk_i); o_lat++; end
    o_res = result_o; o_rd = rd_o; o_ill = illegal_o;
    o_hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      valid_i = 1'b1; rd_i = ~rd; rs1_i = $urandom; funct3_i = 3'($urandom);
      @(negedge clk_i);
      if (result_o !== o_res || rd_o !== o_rd || illegal_o !== o_ill ||
          ready_o !== 1'b0 || result_valid_o !== 1'b1)
        o_hold_bad++;
    end
    valid_i = 1'b0;
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    o_starts = mul_starts + div_starts;
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    outs = {result_valid_o, result_o, rd_o, illegal_o, mul_start_o, mul_op_A_o, mul_op_B_o,
            mul_ext_A_o, mul_ext_B_o, mul_upper_o, 6'd0};
    n_cmp++;
    if (outs !== 112'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++;
    if (result_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_rvalid: got %b want 0", result_valid_o);
    end
  endtask

  task automatic test_mulhu();
    logic [31:0] r; logic [4:0] d; logic il; int lat, st, hb;
    unit_lat = 5;
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 0, r, d, il, lat, st, hb);
    n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL mulhu_res: got %h want fffffffe", r); end
    n_cmp++; if (d !== 5'd13) begin n_err++; $display("FAIL mulhu_rd: got %0d want 13", d); end
    n_cmp++; if (il !== 1'b0) begin n_err++; $display("FAIL mulhu_ill: got %b want 0", il); end
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL mulhu_lat: got %0d want 7", lat); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL mulhu_starts: got %0d want 1", st); end
    n_cmp++;
    if ({m_ea, m_eb, m_up} !== 3'b001) begin
      n_err++; $display("FAIL mulhu_ctl: got %b want 001", {m_ea, m_eb, m_up});
    end
  endtask

  task automatic test_mulhsu();
    logic [31:0] r; logic [4:0] d; logic il; int lat, st, hb;
    unit_lat = 2;
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd7, 0, r, d, il, lat, st, hb);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_res: got %h want ffffffff", r); end
    n_cmp++;
    if ({m_ea, m_eb, m_up} !== 3'b101) begin
      n_err++; $display("FAIL mulhsu_ctl: got %b want 101", {m_ea, m_eb, m_up});
    end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL mulhsu_lat: got %0d want 4", lat); end
  endtask

  task automatic test_hold();
    logic [31:0] r, a, b; logic [4:0] d; logic il; int lat, st, hb; logic [33:0] e;
    unit_lat = 3;
    a = rnd_word(); b = rnd_word(); e = ref_op(3'b001, a, b);
    do_op(3'b001, a, b, 5'd21, 10, r, d, il, lat, st, hb);
    n_cmp++; if (hb !== 0) begin n_err++; $display("FAIL hold_stable: got %0d bad cycles want 0", hb); end
    n_cmp++; if (r !== e[31:0]) begin n_err++; $display("FAIL hold_res: got %h want %h", r, e[31:0]); end
    n_cmp++; if (d !== 5'd21) begin n_err++; $display("FAIL hold_rd: got %0d want 21", d); end
    n_cmp++;
    if (ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
      n_err++; $display("FAIL hold_after: got ready=%b rvalid=%b want 1/0", ready_o, result_valid_o);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] r; logic [4:0] d; logic il; int lat, st, hb;
    unit_lat = 2;
    unit_hang = 1'b1;
    do_op(3'b000, $urandom, $urandom, 5'd3, 0, r, d, il, lat, st, hb);
    unit_hang = 1'b0;
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL wdog_lat: got %0d want 65", lat); end
    n_cmp++; if (r !== 32'd0) begin n_err++; $display("FAIL wdog_res: got %h want 0", r); end
    n_cmp++; if (il !== 1'b1) begin n_err++; $display("FAIL wdog_ill: got %b want 1", il); end
    n_cmp++; if (st !== 1) begin n_err++; $display("FAIL wdog_starts: got %0d want 1", st); end
  endtask

  task automatic test_random(input int count, input bit upper_half);
    logic [31:0] r, a, b; logic [4:0] d, rd; logic il; int lat, st, hb, el, hold;
    logic [2:0] f; logic [33:0] e;
    for (int i = 0; i < count; i++) begin
      f = {upper_half, 2'($urandom)};
      a = rnd_word(); b = rnd_word(); rd = 5'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      unit_lat = $urandom_range(1, 8);
      hold = $urandom_range(0, 3);
      e = ref_op(f, a, b);
      el = e[33] ? 1 : unit_lat + 2;
      do_op(f, a, b, rd, hold, r, d, il, lat, st, hb);
      n_cmp++;
      if (r !== e[31:0] || il !== e[32]) begin
        n_err++; $display("FAIL rand_res f3=%0d a=%h b=%h: got %h/%b want %h/%b", f, a, b, r, il, e[31:0], e[32]);
      end
      n_cmp++; if (d !== rd) begin n_err++; $display("FAIL rand_rd: got %0d want %0d", d, rd); end
      n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rand_lat f3=%0d: got %0d want %0d", f, lat, el); end
      n_cmp++;
      if (st !== (e[33] ? 0 : 1)) begin
        n_err++; $display("FAIL rand_starts f3=%0d: got %0d want %0d", f, st, e[33] ? 0 : 1);
      end
      n_cmp++; if (hb !== 0) begin n_err++; $display("FAIL rand_hold: got %0d bad cycles want 0", hb); end
    end
    n_cmp++;
    if (op_unstable !== 0) begin n_err++; $display("FAIL operand_stable: got %0d changes want 0", op_unstable); end
  endtask

  task automatic test_funct3_1xx();
    logic [31:0] r; logic [4:0] d; logic il; int lat, st, hb;
    logic [2:0] tf[6]; logic [31:0] ta[6], tb[6], tr[6]; logic ti[6];
`ifdef RV32M_DIV_EN
    tf = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    ta = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    tb = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    tr = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
    ti = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    tf = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd6};
    ta = '{32'd7, 32'd7, 32'h8000_0000, 32'd5, 32'd100, 32'd1};
    tb = '{32'd0, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd1};
    tr = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    ti = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    unit_lat = 3;
    for (int i = 0; i < 6; i++) begin
      do_op(tf[i], ta[i], tb[i], 5'(i + 1), 0, r, d, il, lat, st, hb);
      n_cmp++;
      if (r !== tr[i] || il !== ti[i]) begin
        n_err++; $display("FAIL f3_%0d_res: got %h/%b want %h/%b", tf[i], r, il, tr[i], ti[i]);
      end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL f3_%0d_lat: got %0d want 1", tf[i], lat); end
      n_cmp++; if (st !== 0) begin n_err++; $display("FAIL f3_%0d_starts: got %0d want 0", tf[i], st); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [4:0] d; logic il; int lat, st, hb, bad;
    unit_lat = 20;
    mul_starts = 0;
    valid_i = 1'b1; funct3_i = 3'd0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'd9;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (result_valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd0 || rd_o !== 5'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rstmid_idle: got %0d bad cycles want 0", bad); end
    n_cmp++; if (mul_starts !== 1) begin n_err++; $display("FAIL rstmid_starts: got %0d want 1", mul_starts); end
    unit_lat = 2;
    do_op(3'b000, 32'd3, 32'd5, 5'd30, 0, r, d, il, lat, st, hb);
    n_cmp++;
    if (r !== 32'd15 || d !== 5'd30 || il !== 1'b0) begin
      n_err++; $display("FAIL rstmid_recover: got %h/%0d/%b want 0000000f/30/0", r, d, il);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mulhu();
    test_mulhsu();
    test_hold();
    test_watchdog();
    test_random(40, 1'b0);
    test_funct3_1xx();
    test_random(30, 1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32m_dispatch.md
RV32M_DISPATCH -- requirements
Module: rv32m_dispatch

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock, rising edge; rst_i  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have: valid_i  in  1  core request valid; ready_o  out  1  dispatcher accepts request.
REQ-003 SHALL have: funct3_i  in  3  RV32M funct3; rs1_i  in  32  operand 1; rs2_i  in  32  operand 2; rd_i  in  5  destination tag.
REQ-004 SHALL have: result_valid_o  out  1  result valid; result_ready_i  in  1  core takes result; result_o  out  32  result; rd_o  out  5  tag echo; illegal_o  out  1  op not supported.
REQ-005 SHALL have multiplier ports: mul_start_o  out  1  start pulse; mul_op_A_o, mul_op_B_o  out  32  operands; mul_ext_A_o, mul_ext_B_o  out  1  sign-extend A/B; mul_upper_o  out  1  select high word; mul_result_i  in  32; mul_done_i  in  1.
REQ-006 SHALL have divider ports only under RV32M_DIV_EN: div_start_o  out  1; div_op_A_o, div_op_B_o  out  32; div_signed_o  out  1; div_rem_o  out  1; div_result_i  in  32; div_done_i  in  1.

Function
REQ-007 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; ready_o=1 only in IDLE.
REQ-008 SHALL, on valid_i&&ready_o, register funct3, rs1, rs2, rd and go to ISSUE; an unaccepted request is not sampled.
REQ-009 SHALL decode funct3 to (ext_A, ext_B, upper): 000 MUL (1,1,0); 001 MULH (1,1,1); 010 MULHSU (1,0,1); 011 MULHU (0,0,1).
REQ-010 SHALL drive mul_op_A_o/mul_op_B_o/ext/upper from registered values, stable from ISSUE until leaving WAIT.
REQ-011 SHALL assert mul_start_o (or div_start_o) for exactly the single ISSUE cycle, then enter WAIT.
REQ-012 SHALL, in WAIT, on done_i of the selected unit, capture its result into result_o and enter RESP; done_i of the non-selected unit and any done_i outside WAIT are ignored.
REQ-013 SHALL hold a 6-bit watchdog counter cleared in ISSUE, incremented each WAIT cycle; reaching 63 without done forces result_o=0, illegal_o=1, go to RESP.
REQ-014 SHALL, in RESP, hold result_valid_o=1 with result_o, rd_o, illegal_o stable until result_ready_i=1, then return to IDLE; next request not accepted in that same cycle (one idle bubble).
REQ-015 SHALL, for divide by zero (rs2=0), skip ISSUE/WAIT and go IDLE->RESP: DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1.
REQ-016 SHALL, for signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF), go IDLE->RESP: DIV result 0x80000000, REM result 0.
REQ-017 SHALL give minimum request-to-result_valid latency: ISSUE(1) + unit latency + 1 capture cycle; special cases exactly 1 cycle.

Reset
REQ-018 SHALL, on rst_i at any time including mid-operation, go to IDLE; all outputs 0 except ready_o, which is 1 after reset release; watchdog and operand registers cleared.
REQ-019 SHALL discard an in-flight operation on reset; a late done_i after reset is ignored (FSM in IDLE).

Configuration
REQ-020 SHALL, with RV32M_DIV_EN defined, dispatch funct3 1xx to divider: 100 DIV (signed,quot), 101 DIVU, 110 REM (signed,rem), 111 REMU, with REQ-015/016 special cases applied.
REQ-021 SHALL, without RV32M_DIV_EN, omit divider ports and logic; funct3 1xx goes IDLE->RESP with result_o=0, illegal_o=1.

Verification
REQ-022 MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF, model returns 0xFFFFFFFE after 5 cycles -> mul_start_o one pulse with ext=(0,0), upper=1; result_o=0xFFFFFFFE, rd_o echoes rd_i.
REQ-023 MULHSU rs1=0xFFFFFFFF rs2=2 -> ext_A=1, ext_B=0, upper=1; result_o equals model value 0xFFFFFFFF.
REQ-024 DIV rs1=7 rs2=0 (macro on) -> no div_start_o, result_valid_o next cycle, result_o=0xFFFFFFFF; REM same operands -> 7.
REQ-025 Multiplier never asserts done -> result_valid_o after 63 WAIT cycles with result_o=0, illegal_o=1.
REQ-026 result_ready_i held low 10 cycles in RESP -> result_o/rd_o stable, ready_o=0 throughout; valid_i ignored.
REQ-027 rst_i pulsed during WAIT, then done_i -> FSM IDLE, result_valid_o stays 0, ready_o=1; macro off: funct3=100 -> illegal_o=1, result_o=0.
